// File: rtl/axi_wr_dispatch_if.sv
// Bundle of the write-beat input, the completion pulses, the IRAM/WRAM write ports
// and the command-FIFO consumer port for axi_wr_dispatch.
interface axi_wr_dispatch_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WDATA_WIDTH = 32,
  parameter int RAM_AW      = 9,
  parameter int FIFO_DEPTH  = 8
);
  localparam int BE_W  = WDATA_WIDTH / 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                        axi_wr_vld;
  logic [ADDR_WIDTH-1:0]       axi_wr_addr;
  logic [WDATA_WIDTH-1:0]      axi_wr_data;
  logic [WDATA_WIDTH-1:0]      axi_wr_strb;
  logic [1:0]                  axi_wr_region;

  logic                        fifo_wr_done;
  logic                        fifo_err;
  logic                        iram_wr_done;
  logic                        wram_wr_done;

  logic                        iram_we;
  logic [RAM_AW-1:0]           iram_addr;
  logic [WDATA_WIDTH-1:0]      iram_wdata;
  logic [BE_W-1:0]             iram_be;
  logic                        iram_ready;

  logic                        wram_we;
  logic [RAM_AW-1:0]           wram_addr;
  logic [WDATA_WIDTH-1:0]      wram_wdata;
  logic [BE_W-1:0]             wram_be;
  logic                        wram_ready;

  logic                        fifo_rd_en;
  logic [WDATA_WIDTH+BE_W-1:0] fifo_rd_data;
  logic                        fifo_empty;
  logic [CNT_W-1:0]            fifo_count;

  modport slave (
    input  axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
    input  iram_ready, wram_ready, fifo_rd_en,
    output fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done,
    output iram_we, iram_addr, iram_wdata, iram_be,
    output wram_we, wram_addr, wram_wdata, wram_be,
    output fifo_rd_data, fifo_empty, fifo_count
  );

  modport master (
    output axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
    output iram_ready, wram_ready, fifo_rd_en,
    input  fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done,
    input  iram_we, iram_addr, iram_wdata, iram_be,
    input  wram_we, wram_addr, wram_wdata, wram_be,
    input  fifo_rd_data, fifo_empty, fifo_count
  );
endinterface

// File: rtl/axi_wr_dispatch.sv
// Routes one AXI write beat by region to the command FIFO, IRAM or WRAM and returns completion pulses.
// Optional saturating error counter (ovf_cnt/ovf_clr) enabled by macro AXI_WR_DISPATCH_OVF_CNT_EN.
module axi_wr_dispatch #(
  parameter int ADDR_WIDTH  = 11,
  parameter int WDATA_WIDTH = 32,
  parameter int RAM_AW      = 9,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic clk,
  input  logic rst,
  axi_wr_dispatch_if.slave bus
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
  ,
  input  logic       ovf_clr,
  output logic [7:0] ovf_cnt
`endif
);
  localparam int BE_W  = WDATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = WDATA_WIDTH + BE_W;

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = FIFO_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IRAM_WR = 2'd1,
    WRAM_WR = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [RAM_AW-1:0]      ram_addr_q, ram_addr_d;
  logic [WDATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic [BE_W-1:0]        ram_be_q, ram_be_d;
  logic                   fifo_done_q, fifo_done_d;
  logic                   fifo_err_q, fifo_err_d;
  logic                   iram_done_q, iram_done_d;
  logic                   wram_done_q, wram_done_d;

  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q;

  logic [BE_W-1:0]        be_s;
  logic [RAM_AW-1:0]      word_addr_s;
  logic                   full_s, empty_s, pop_s, push_s;

  // Byte enable k is taken from the low bit of each byte-expanded strobe lane
  always_comb begin
    be_s = '0;
    for (int k = 0; k < BE_W; k++) begin
      be_s[k] = bus.axi_wr_strb[8*k];
    end
  end

  assign word_addr_s = RAM_AW'(bus.axi_wr_addr[ADDR_WIDTH-1:2]);
  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == '0);
  assign pop_s       = bus.fifo_rd_en & ~empty_s;
  // A full FIFO still accepts when the consumer frees the head in the same cycle
  assign push_s      = (state_q == IDLE) & bus.axi_wr_vld & (bus.axi_wr_region == 2'd0)
                       & (~full_s | pop_s);

  // Dispatch next-state, beat capture and completion pulse generation
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_be_d    = ram_be_q;
    fifo_done_d = 1'b0;
    fifo_err_d  = 1'b0;
    iram_done_d = 1'b0;
    wram_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.axi_wr_vld) begin
          case (bus.axi_wr_region)
            2'd0: begin
              fifo_done_d = 1'b1;
              fifo_err_d  = ~push_s;
            end
            2'd1: begin
              state_d    = IRAM_WR;
              ram_addr_d = word_addr_s;
              ram_data_d = bus.axi_wr_data;
              ram_be_d   = be_s;
            end
            2'd2: begin
              state_d    = WRAM_WR;
              ram_addr_d = word_addr_s;
              ram_data_d = bus.axi_wr_data;
              ram_be_d   = be_s;
            end
            default: begin
              fifo_done_d = 1'b1;
              fifo_err_d  = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      IRAM_WR: begin
        if (bus.iram_ready) begin
          state_d     = IDLE;
          iram_done_d = 1'b1;
        end else begin
          state_d = IRAM_WR;
        end
      end
      WRAM_WR: begin
        if (bus.wram_ready) begin
          state_d     = IDLE;
          wram_done_d = 1'b1;
        end else begin
          state_d = WRAM_WR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dispatch state, captured beat and completion pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_be_q    <= '0;
      fifo_done_q <= 1'b0;
      fifo_err_q  <= 1'b0;
      iram_done_q <= 1'b0;
      wram_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_be_q    <= ram_be_d;
      fifo_done_q <= fifo_done_d;
      fifo_err_q  <= fifo_err_d;
      iram_done_q <= iram_done_d;
      wram_done_q <= wram_done_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap because the depth is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {be_s, bus.axi_wr_data};
    end
  end

  assign bus.fifo_wr_done = fifo_done_q;
  assign bus.fifo_err     = fifo_err_q;
  assign bus.iram_wr_done = iram_done_q;
  assign bus.wram_wr_done = wram_done_q;

  assign bus.iram_we      = (state_q == IRAM_WR);
  assign bus.iram_addr    = ram_addr_q;
  assign bus.iram_wdata   = ram_data_q;
  assign bus.iram_be      = ram_be_q;
  assign bus.wram_we      = (state_q == WRAM_WR);
  assign bus.wram_addr    = ram_addr_q;
  assign bus.wram_wdata   = ram_data_q;
  assign bus.wram_be      = ram_be_q;

  assign bus.fifo_rd_data = mem_q[rd_ptr_q];
  assign bus.fifo_empty   = empty_s;
  assign bus.fifo_count   = count_q;

`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Counts error completions, saturating; clear wins over a coincident increment
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end else if (fifo_err_d && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Scoreboard bench for axi_wr_dispatch: stimulus queues expected completions, RAM handshakes and
// FIFO pops; a negedge monitor compares them as the DUT presents them.
module tb_axi_wr_dispatch;
  logic clk;
  logic rst;

  axi_wr_dispatch_if #(.ADDR_WIDTH(11), .WDATA_WIDTH(32), .RAM_AW(9), .FIFO_DEPTH(8)) bus ();

`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
  logic       ovf_clr;
  logic [7:0] ovf_cnt;
`endif

  axi_wr_dispatch #(.ADDR_WIDTH(11), .WDATA_WIDTH(32), .RAM_AW(9), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
    ,
    .ovf_clr (ovf_clr),
    .ovf_cnt (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // done kinds: 0 fifo ok, 1 fifo err, 2 iram, 3 wram
  int          done_q[$];
  logic [46:0] ram_q[$];   // {target[1:0], addr[8:0], be[3:0], data[31:0]}
  logic [35:0] rd_q[$];    // {be[3:0], data[31:0]}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] rg, input logic [10:0] a, input logic [31:0] d,
                      input logic [31:0] s);
    bus.axi_wr_vld    = 1'b1;
    bus.axi_wr_region = rg;
    bus.axi_wr_addr   = a;
    bus.axi_wr_data   = d;
    bus.axi_wr_strb   = s;
    tick();
    bus.axi_wr_vld    = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse, handshake or pop
  always @(negedge clk) begin
    int          kind;
    logic [46:0] ram_act;
    if (!rst) begin
      if (bus.fifo_wr_done | bus.iram_wr_done | bus.wram_wr_done) begin
        check("done_onehot", 64'($countones({bus.fifo_wr_done, bus.iram_wr_done, bus.wram_wr_done})), 64'd1);
        kind = bus.fifo_wr_done ? (bus.fifo_err ? 1 : 0) : (bus.iram_wr_done ? 2 : 3);
        if (done_q.size() == 0) check("done_unexpected", 64'(kind), 64'd99);
        else check("done_kind", 64'(kind), 64'(done_q.pop_front()));
      end
      if ((bus.iram_we & bus.iram_ready) | (bus.wram_we & bus.wram_ready)) begin
        if (bus.iram_we) ram_act = {2'd1, bus.iram_addr, bus.iram_be, bus.iram_wdata};
        else             ram_act = {2'd2, bus.wram_addr, bus.wram_be, bus.wram_wdata};
        if (ram_q.size() == 0) check("ram_unexpected", 64'(ram_act), 64'h0);
        else check("ram_write", 64'(ram_act), 64'(ram_q.pop_front()));
      end
      if (bus.fifo_rd_en & ~bus.fifo_empty) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(bus.fifo_rd_data), 64'h0);
        else check("fifo_rd_data", 64'(bus.fifo_rd_data), 64'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [31:0] s;
    logic [3:0]  be;
    rst = 1'b1;
    bus.axi_wr_vld = 1'b0; bus.axi_wr_addr = '0; bus.axi_wr_data = '0;
    bus.axi_wr_strb = '0;  bus.axi_wr_region = 2'd0;
    bus.iram_ready = 1'b0; bus.wram_ready = 1'b0; bus.fifo_rd_en = 1'b0;
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) tick();
    check("rst_done", {bus.fifo_wr_done, bus.fifo_err, bus.iram_wr_done, bus.wram_wr_done}, 64'h0);
    check("rst_we", {bus.iram_we, bus.wram_we}, 64'h0);
    check("rst_empty", bus.fifo_empty, 64'h1);
    check("rst_count", bus.fifo_count, 64'h0);
    check("rst_ram_bus", {bus.iram_addr, bus.iram_wdata, bus.iram_be}, 64'h0);
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
    check("rst_ovf_cnt", ovf_cnt, 64'h0);
`endif
    rst = 1'b0;
    tick();

    // IRAM write held off by ready for 3 cycles
    ram_q.push_back({2'd1, 9'h004, 4'hF, 32'hDEADBEEF});
    done_q.push_back(2);
    beat(2'd1, 11'h010, 32'hDEADBEEF, 32'h01010101);
    for (int i = 0; i < 3; i++) begin
      check("iram_we_wait", bus.iram_we, 64'h1);
      check("iram_addr_wait", bus.iram_addr, 64'h004);
      tick();
    end
    bus.iram_ready = 1'b1;
    check("iram_we_hs", bus.iram_we, 64'h1);
    tick();
    bus.iram_ready = 1'b0;
    check("iram_we_after", bus.iram_we, 64'h0);
    check("iram_done_pulse", bus.iram_wr_done, 64'h1);
    tick();
    check("iram_done_single", bus.iram_wr_done, 64'h0);

    // WRAM write with ready tied high
    bus.wram_ready = 1'b1;
    ram_q.push_back({2'd2, 9'h1FF, 4'hA, 32'h12345678});
    done_q.push_back(3);
    beat(2'd2, 11'h7FC, 32'h12345678, 32'h01000100);
    check("wram_we_1", bus.wram_we, 64'h1);
    check("wram_done_early", bus.wram_wr_done, 64'h0);
    tick();
    check("wram_we_2", bus.wram_we, 64'h0);
    check("wram_done_lat2", bus.wram_wr_done, 64'h1);
    bus.wram_ready = 1'b0;
    tick();

    // Nine region-0 beats with no pops: eight fit, the ninth overflows
    for (int i = 0; i < 9; i++) begin
      d  = 32'hC0DE0000 + 32'(i);
      s  = (i % 2 == 1) ? 32'h01010101 : 32'h00010001;
      be = (i % 2 == 1) ? 4'hF : 4'h5;
      if (i < 8) begin
        rd_q.push_back({be, d});
        done_q.push_back(0);
      end else begin
        done_q.push_back(1);
      end
      beat(2'd0, 11'h000, d, s);
    end
    check("fifo_count_full", bus.fifo_count, 64'd8);
    check("fifo_ovf_err", {bus.fifo_wr_done, bus.fifo_err}, 64'h3);
    tick();

    // Full FIFO with a same-cycle pop still accepts the beat
    rd_q.push_back({4'h3, 32'hF00D0009});
    done_q.push_back(0);
    bus.fifo_rd_en = 1'b1;
    beat(2'd0, 11'h000, 32'hF00D0009, 32'h00000101);
    bus.fifo_rd_en = 1'b0;
    check("full_pop_count", bus.fifo_count, 64'd8);
    check("full_pop_err", {bus.fifo_wr_done, bus.fifo_err}, 64'h2);
    tick();

    // Drain, then one pop on an empty FIFO
    bus.fifo_rd_en = 1'b1;
    repeat (9) tick();
    bus.fifo_rd_en = 1'b0;
    check("drain_count", bus.fifo_count, 64'd0);
    check("drain_empty", bus.fifo_empty, 64'h1);

    // Region 3 decode error
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf_cnt, 64'h0);
`endif
    done_q.push_back(1);
    beat(2'd3, 11'h100, 32'h55555555, 32'h01010101);
    check("r3_err", {bus.fifo_wr_done, bus.fifo_err}, 64'h3);
    check("r3_no_ram", {bus.iram_we, bus.wram_we}, 64'h0);
    check("r3_no_fifo", bus.fifo_count, 64'd0);
`ifdef AXI_WR_DISPATCH_OVF_CNT_EN
    check("r3_ovf_cnt", ovf_cnt, 64'h1);
`endif
    tick();

    // Reset while an IRAM write waits for ready
    beat(2'd1, 11'h020, 32'hABCD0123, 32'h01010101);
    tick();
    check("rst_mid_we", bus.iram_we, 64'h1);
    rst = 1'b1;
    #1;
    check("rst_async_we", bus.iram_we, 64'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", {bus.iram_we, bus.iram_wr_done}, 64'h0);
    end
    bus.iram_ready = 1'b1;
    ram_q.push_back({2'd1, 9'h00A, 4'h9, 32'h0BADF00D});
    done_q.push_back(2);
    beat(2'd1, 11'h028, 32'h0BADF00D, 32'h01000001);
    check("post_rst_we", bus.iram_we, 64'h1);
    tick();
    bus.iram_ready = 1'b0;
    check("post_rst_done", bus.iram_wr_done, 64'h1);

    repeat (3) tick();
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    check("ram_q_empty", 64'(ram_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
